// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: applies at most STEP single-bit shifts per clock
// (SLL/SRL/SRA/ROTR) behind valid/ready handshakes on input and output.
module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_SLL  = 2'b00,
        M_SRL  = 2'b01,
        M_SRA  = 2'b10,
        M_ROTR = 2'b11
    } mode_t;

    localparam logic [SHAMT_W-1:0] C_STEP = SHAMT_W'(STEP);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_rem;
    mode_t              r_mode;

    logic [SHAMT_W-1:0] w_k;
    logic [SHAMT_W-1:0] w_rem_next;
    logic [WIDTH-1:0]   w_shifted;

    assign w_k        = (r_rem < C_STEP) ? r_rem : C_STEP;
    assign w_rem_next = r_rem - w_k;

    // Chain of STEP one-bit stages; only the first w_k are enabled, so SRA keeps
    // replicating the sign and ROTR wraps naturally even when the amount >= WIDTH.
    always_comb begin
        w_shifted = r_data;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (SHAMT_W'(i) < w_k) begin
                case (r_mode)
                    M_SLL:   w_shifted = {w_shifted[WIDTH-2:0], 1'b0};
                    M_SRL:   w_shifted = {1'b0, w_shifted[WIDTH-1:1]};
                    M_SRA:   w_shifted = {w_shifted[WIDTH-1], w_shifted[WIDTH-1:1]};
                    default: w_shifted = {w_shifted[0], w_shifted[WIDTH-1:1]};
                endcase
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = (in_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (w_rem_next == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_rem   <= '0;
            r_mode  <= M_SLL;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data <= in_data;
                        r_rem  <= in_shamt;
                        r_mode <= mode_t'(in_mode);
                    end
                end
                SHIFT: begin
                    r_data <= w_shifted;
                    r_rem  <= w_rem_next;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !reset;
    assign out_valid = (r_state == DONE);
    assign out_data  = r_data;
    assign out_zero  = (r_data == '0);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: three instances (STEP 4, 1, 7) checked against a direct
// shift model through per-instance scoreboards, plus directed handshake scenarios.
module tb_iter_shifter;

    localparam int W  = 32;
    localparam int SW = 5;
    localparam int N  = 3;

    function automatic int step_of(input int g);
        return (g == 0) ? 4 : (g == 1) ? 1 : 7;
    endfunction

    function automatic int lat_of(input int s, input int step);
        return (s == 0) ? 1 : 1 + (s + step - 1) / step;
    endfunction

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [SW-1:0] s,
                                               input logic [1:0] m);
        int unsigned      sh;
        int unsigned      r;
        logic [W-1:0]     res;
        sh = s;
        r  = sh % W;
        case (m)
            2'b00:   res = (sh >= W) ? '0 : d << sh;
            2'b01:   res = (sh >= W) ? '0 : d >> sh;
            2'b10:   res = (sh >= W) ? {W{d[W-1]}} : W'($signed(d) >>> sh);
            default: res = (r == 0) ? d : ((d >> r) | (d << (W - r)));
        endcase
        return res;
    endfunction

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [W-1:0]      in_data;
    logic [SW-1:0]     in_shamt;
    logic [1:0]        in_mode;
    logic [N-1:0]      out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data [N];
    logic [N-1:0]      out_zero;
    logic [N-1:0]      busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        iter_shifter #(.WIDTH(W), .SHAMT_W(SW), .STEP(step_of(g))) u_dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data),
            .in_shamt (in_shamt),
            .in_mode  (in_mode),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .out_data (out_data[g]),
            .out_zero (out_zero[g]),
            .busy     (busy[g])
        );

        logic [W-1:0] exp_q[$];
        logic [W-1:0] e;
        int           acc_cyc;
        int           exp_lat;
        bit           pend = 1'b0;

        // Scoreboard: push at acceptance, measure latency to first out_valid, pop on hand-off.
        always @(negedge clk) begin
            if (reset) begin
                exp_q.delete();
                pend = 1'b0;
            end else begin
                if (out_valid[g] && pend) begin
                    pend = 1'b0;
                    check($sformatf("latency_s%0d", step_of(g)), 64'(cyc - acc_cyc), 64'(exp_lat));
                end
                if (out_valid[g] && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected_valid_s%0d", step_of(g)), 64'(out_valid[g]), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("data_s%0d", step_of(g)), 64'(out_data[g]), 64'(e));
                        check($sformatf("zero_s%0d", step_of(g)), 64'(out_zero[g]), 64'(e == '0));
                    end
                end
                if (in_valid[g] && in_ready[g]) begin
                    exp_q.push_back(ref_shift(in_data, in_shamt, in_mode));
                    acc_cyc = cyc;
                    exp_lat = lat_of(int'(in_shamt), step_of(g));
                    pend    = 1'b1;
                end
            end
        end
    end

    task automatic send(input int g, input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] m);
        bit ok = 1'b0;
        @(posedge clk); #1;
        in_valid[g] = 1'b1;
        in_data     = d;
        in_shamt    = s;
        in_mode     = m;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready[g];
        end
        if (!ok) check("accept_timeout", 64'(in_ready[g]), 64'd1);
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
        in_data     = $urandom;
        in_shamt    = SW'($urandom);
        in_mode     = 2'($urandom);
    endtask

    task automatic expect_at(input int lat, input logic [W-1:0] exp, input string tag);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check({tag, "_early"}, 64'(out_valid[0]), 64'd0);
        end
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid[0]), 64'd1);
        check({tag, "_data"}, 64'(out_data[0]), 64'(exp));
        check({tag, "_zero"}, 64'(out_zero[0]), 64'(exp == '0));
    endtask

    task automatic drain();
        bit idle = 1'b0;
        for (int t = 0; t < 300 && !idle; t++) begin
            @(negedge clk);
            idle = (busy == '0);
        end
        if (!idle) check("drain_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [W-1:0]  d;
        logic [SW-1:0] s;
        logic [1:0]    m;
        logic [N-1:0]  pending;
        logic [N-1:0]  acc;
        logic          seen;
        int            cnt;

        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready[0]), 64'd0);
        check("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check("rst_out_data", 64'(out_data[0]), 64'd0);
        check("rst_out_zero", 64'(out_zero[0]), 64'd1);
        check("rst_busy", 64'(busy[0]), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready[0]), 64'd1);

        send(0, 32'hFFFF_FFFF, 5'd2, 2'b00);
        expect_at(2, 32'hFFFF_FFFC, "legacy_sll2");
        drain();
        send(0, 32'h8000_0000, 5'd31, 2'b10);
        expect_at(9, 32'hFFFF_FFFF, "sra31");
        drain();
        send(0, 32'h8000_0000, 5'd31, 2'b01);
        expect_at(9, 32'h0000_0001, "srl31");
        drain();
        send(0, 32'h1234_5678, 5'd8, 2'b11);
        expect_at(3, 32'h7812_3456, "rotr8");
        drain();
        for (int k = 0; k < 4; k++) begin
            send(0, 32'hDEAD_BEEF, 5'd0, 2'(k));
            expect_at(1, 32'hDEAD_BEEF, $sformatf("shamt0_m%0d", k));
            drain();
        end
        send(0, 32'h0000_0003, 5'd1, 2'b01);
        expect_at(2, 32'h0000_0001, "srl1");
        drain();
        send(0, 32'h0000_0001, 5'd1, 2'b01);
        expect_at(2, 32'h0000_0000, "srl_to_zero");
        drain();

        // Backpressure: result and flags hold while the consumer stalls.
        out_ready = 1'b0;
        send(0, 32'h1234_5678, 5'd8, 2'b11);
        expect_at(3, 32'h7812_3456, "bp_first");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid[0]), 64'd1);
            check("bp_out_data", 64'(out_data[0]), 64'h7812_3456);
            check("bp_in_ready", 64'(in_ready[0]), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(out_valid[0]), 64'd1);
        @(negedge clk);
        check("bp_after_valid", 64'(out_valid[0]), 64'd0);
        check("bp_after_in_ready", 64'(in_ready[0]), 64'd1);

        // Reset during the third SHIFT cycle aborts the operation.
        send(0, 32'h0000_0001, 5'd20, 2'b00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_out_data", 64'(out_data[0]), 64'd0);
        check("abort_out_zero", 64'(out_zero[0]), 64'd1);
        check("abort_in_ready", 64'(in_ready[0]), 64'd1);
        seen = out_valid[0];
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seen = seen | out_valid[0];
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        send(0, 32'h0000_0001, 5'd4, 2'b00);
        expect_at(2, 32'h0000_0010, "post_abort_sll4");
        drain();

        // in_valid held high: acceptance only on IDLE cycles (one per 3 cycles here).
        cnt = 0;
        @(posedge clk); #1;
        in_valid[0] = 1'b1;
        in_data     = 32'h0000_00F0;
        in_shamt    = 5'd4;
        in_mode     = 2'b01;
        repeat (12) begin
            @(negedge clk);
            if (in_valid[0] && in_ready[0]) cnt++;
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("held_valid_accepts", 64'(cnt), 64'd4);
        drain();

        // Randomised sweep across all instances with random consumer stalls.
        for (int n = 0; n < 40; n++) begin
            d = (n == 2) ? 32'h0 : $urandom;
            s = (n == 0) ? 5'd31 : (n == 1) ? 5'd0 : SW'($urandom_range(0, 31));
            m = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            in_valid = '1;
            in_data  = d;
            in_shamt = s;
            in_mode  = m;
            pending  = '1;
            for (int t = 0; t < 300 && pending != '0; t++) begin
                @(negedge clk);
                acc = pending & in_ready;
                @(posedge clk); #1;
                in_valid  = in_valid & ~acc;
                pending   = pending & ~acc;
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (pending != '0) check("sweep_accept_timeout", 64'(pending), 64'd0);
        end
        in_valid  = '0;
        out_ready = 1'b1;
        drain();
        repeat (2) @(negedge clk);
        check("q_empty_s4", 64'(g_dut[0].exp_q.size()), 64'd0);
        check("q_empty_s1", 64'(g_dut[1].exp_q.size()), 64'd0);
        check("q_empty_s7", 64'(g_dut[2].exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
